usb_tx_crc_seq: RTL and testbench

Parametrised successor to the single-shot transmit sequencer. It is a packet transmit engine.
- On a start request it streams LEN payload bytes from an upstream valid/ready source to a downstream valid/ready sink.
- It then appends a CRC-16/USB trailer in two states, CRC1 and CRC2.
- It keeps a configurable-depth shift history of accepted beats for FSM-extraction and debug checks.
- It sits between the packet buffer and the USB PHY byte interface.

---
 rtl/usb_tx_pkg.sv | 26 ++
 rtl/usb_crc16_byte.sv | 26 ++
 rtl/usb_tx_crc_seq.sv | 156 +++++++++++++++
 tb/tb_usb_tx_crc_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB transmit sequencer: FSM state encoding, byte width and
// CRC-16/USB constants, plus a bit-reverse helper for deriving the reflected polynomial.
package usb_tx_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StData = 2'b01,
    StCrc1 = 2'b10,
    StCrc2 = 2'b11
  } tx_state_e;

  localparam logic [15:0] CRC16_POLY   = 16'h8005;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_XOROUT = 16'hFFFF;

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      r[i] = v[15-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// One-byte combinational CRC-16/USB update (reflected in/out form, LSB of data first).
// Ports:
//   crc_i  - running CRC before this byte
//   data_i - payload byte
//   crc_o  - running CRC after this byte (no final xor applied)
module usb_crc16_byte
  import usb_tx_pkg::*;
(
  input  logic [15:0]       crc_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic [15:0]       crc_o
);

  // Reflected processing shifts right, so the polynomial is used bit-reversed (0xA001).
  localparam logic [15:0] PolyRefl = rev16(CRC16_POLY);

  always_comb begin
    logic [15:0] c;
    c = crc_i ^ {8'h00, data_i};
    for (int i = 0; i < BYTE_W; i++) begin
      c = c[0] ? ((c >> 1) ^ PolyRefl) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/usb_tx_crc_seq.sv
// Packet transmit engine between the packet buffer and the USB PHY byte interface.
// On send_data_i in IDLE it streams len_i payload bytes from the upstream valid/ready source
// to the downstream valid/ready sink, then (with USB_TX_CRC_EN defined) appends the
// CRC-16/USB trailer, low byte first. Without USB_TX_CRC_EN the CRC and trailer states are
// not built and the packet ends on the last payload beat.
// Ports:
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   send_data_i, len_i     - start request and payload length (sampled in IDLE only)
//   in_data_i/in_valid_i/in_ready_o - upstream byte stream
//   tx_data_o/tx_valid_o/tx_ready_i - downstream byte stream (registered data/valid)
//   busy_o                 - state is not IDLE
//   done_o                 - pulse on the final downstream beat of a packet
//   buff_o                 - history of downstream handshakes, bit 0 newest
module usb_tx_crc_seq
  import usb_tx_pkg::*;
#(
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned HIST_DEPTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  send_data_i,
  input  logic [LEN_W-1:0]      len_i,
  input  logic [BYTE_W-1:0]     in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [BYTE_W-1:0]     tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [HIST_DEPTH-1:0] buff_o
);

  tx_state_e             state_q;
  logic [LEN_W-1:0]      cnt_q;
  logic [BYTE_W-1:0]     tx_data_q;
  logic                  tx_valid_q;
  logic                  last_q;  // byte held in the output register ends the packet
  logic [HIST_DEPTH-1:0] buff_q;
  logic                  empty_done;

  logic out_free;
  logic hs;
  logic in_acc;

  assign out_free   = !tx_valid_q || tx_ready_i;
  assign hs         = tx_valid_q && tx_ready_i;
  // The counter gate keeps in_ready low while the last payload byte waits to drain.
  assign in_ready_o = (state_q == StData) && (cnt_q != '0) && out_free;
  assign in_acc     = in_ready_o && in_valid_i;
  assign done_o     = (hs && last_q) || empty_done;

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = (state_q != StIdle);
  assign buff_o     = buff_q;

`ifdef USB_TX_CRC_EN
  logic [15:0] crc_q;
  logic [15:0] crc_next;
  logic [15:0] crc_fin;

  usb_crc16_byte u_crc (
    .crc_i  (crc_q),
    .data_i (in_data_i),
    .crc_o  (crc_next)
  );

  assign crc_fin    = crc_q ^ CRC16_XOROUT;
  assign empty_done = 1'b0;
`else
  logic empty_done_q;  // done for a zero-length packet, one cycle after the request
  assign empty_done = empty_done_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      last_q       <= 1'b0;
      buff_q       <= '0;
`ifdef USB_TX_CRC_EN
      crc_q        <= CRC16_INIT;
`else
      empty_done_q <= 1'b0;
`endif
    end else begin
      buff_q <= {buff_q[HIST_DEPTH-2:0], hs};
      // A drained register goes empty unless a load below refills it in the same cycle.
      if (hs) tx_valid_q <= 1'b0;
`ifndef USB_TX_CRC_EN
      empty_done_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (send_data_i) begin
            cnt_q  <= len_i;
            last_q <= 1'b0;
`ifdef USB_TX_CRC_EN
            crc_q   <= CRC16_INIT;
            state_q <= (len_i != '0) ? StData : StCrc1;
`else
            if (len_i != '0) state_q <= StData;
            else empty_done_q <= 1'b1;
`endif
          end
        end
        StData: begin
          if (in_acc) begin
            tx_data_q  <= in_data_i;
            tx_valid_q <= 1'b1;
            cnt_q      <= cnt_q - LEN_W'(1);
`ifdef USB_TX_CRC_EN
            crc_q <= crc_next;
            if (cnt_q == LEN_W'(1)) state_q <= StCrc1;
`else
            if (cnt_q == LEN_W'(1)) last_q <= 1'b1;
`endif
          end
`ifndef USB_TX_CRC_EN
          if (hs && last_q) begin
            state_q <= StIdle;
            last_q  <= 1'b0;
          end
`endif
        end
`ifdef USB_TX_CRC_EN
        StCrc1: begin
          if (out_free) begin
            tx_data_q  <= crc_fin[7:0];
            tx_valid_q <= 1'b1;
            state_q    <= StCrc2;
          end
        end
        StCrc2: begin
          if (last_q) begin
            if (hs) begin
              state_q <= StIdle;
              last_q  <= 1'b0;
            end
          end else if (out_free) begin
            tx_data_q  <= crc_fin[15:8];
            tx_valid_q <= 1'b1;
            last_q     <= 1'b1;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_crc_seq.sv
// Randomised self-checking bench for usb_tx_crc_seq. The reference model is a byte queue:
// the payload followed (when USB_TX_CRC_EN is defined) by a bit-serial CRC-16/USB trailer.
module tb_usb_tx_crc_seq;

  localparam int unsigned LEN_W      = 8;
  localparam int unsigned HIST_DEPTH = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  send_data;
  logic [LEN_W-1:0]      len_in;
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  busy;
  logic                  done;
  logic [HIST_DEPTH-1:0] buff;

  usb_tx_crc_seq #(
    .LEN_W      (LEN_W),
    .HIST_DEPTH (HIST_DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .send_data_i (send_data),
    .len_i       (len_in),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .tx_data_o   (tx_data),
    .tx_valid_o  (tx_valid),
    .tx_ready_i  (tx_ready),
    .busy_o      (busy),
    .done_o      (done),
    .buff_o      (buff)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pay[$];
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

`ifdef USB_TX_CRC_EN
  // MSB-first CRC on bit-reflected input, output reflected afterwards.
  function automatic logic [15:0] crc_model();
    logic [15:0] r;
    logic [15:0] o;
    logic        fb;
    r = 16'hFFFF;
    foreach (pay[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = r[15] ^ pay[i][k];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h8005;
      end
    end
    for (int j = 0; j < 16; j++) o[j] = r[15-j];
    return o ^ 16'hFFFF;
  endfunction
`endif

  task automatic load_check_string();
    pay = {};
    for (int i = 0; i < 9; i++) pay.push_back(8'(8'h31 + i));
  endtask

  // rdy_mode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
  // vld_mode: 0 always valid, 1 every other cycle, 2 random.
  task automatic run_packet(input int rdy_mode, input int vld_mode, input bit poke_start);
    int         len;
    int         cyc;
    int         src;
    int         nbeats;
    int         first_hs;
    int         last_hs;
    bit         fin;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic [7:0] e;
    logic [HIST_DEPTH-1:0] hmask;
    logic [HIST_DEPTH-1:0] hexp;
`ifdef USB_TX_CRC_EN
    logic [15:0] crc;
`endif
    len   = pay.size();
    exp_q = pay;
`ifdef USB_TX_CRC_EN
    crc = crc_model();
    exp_q.push_back(crc[7:0]);
    exp_q.push_back(crc[15:8]);
`else
    if (len == 0) begin
      @(negedge clk);
      send_data = 1'b1;
      len_in    = '0;
      in_valid  = 1'b0;
      tx_ready  = 1'b1;
      #1 check_eq("z_done_pre", 32'(done), 0);
      @(negedge clk);
      send_data = 1'b0;
      #1;
      check_eq("z_done", 32'(done), 1);
      check_eq("z_busy", 32'(busy), 0);
      check_eq("z_in_ready", 32'(in_ready), 0);
      @(negedge clk);
      #1 check_eq("z_done_clr", 32'(done), 0);
      return;
    end
`endif
    nbeats = exp_q.size();
    obs_q  = {};

    @(negedge clk);
    send_data = 1'b1;
    len_in    = LEN_W'(len);
    in_valid  = 1'b0;
    tx_ready  = 1'b1;
    #1 check_eq("start_busy", 32'(busy), 0);
    @(negedge clk);
    send_data = 1'b0;

    cyc = 0; src = 0; fin = 0; prev_stall = 0; prev_data = '0; first_hs = -1; last_hs = 0;
    while (!fin && cyc < 400) begin
      case (rdy_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 3 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      in_valid  = (src < len) && ((vld_mode == 0) || (vld_mode == 1 && cyc % 2 == 0) ||
                                  (vld_mode == 2 && $urandom_range(0, 1) == 1));
      in_data   = (src < len) ? pay[src] : 8'($urandom);
      send_data = poke_start && (cyc == 3);
      if (send_data) len_in = LEN_W'(5);
      #1;
      check_eq("busy", 32'(busy), 1);
      if (prev_stall) begin
        check_eq("stall_valid", 32'(tx_valid), 1);
        check_eq("stall_data", 32'(tx_data), 32'(prev_data));
      end
      if (src >= len) check_eq("in_ready_off", 32'(in_ready), 0);
      if (in_ready && in_valid) src++;
      if (tx_valid && tx_ready) begin
        obs_q.push_back(tx_data);
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", 32'(obs_q.size()), 32'(nbeats));
        end else begin
          e = exp_q.pop_front();
          check_eq("beat_data", 32'(tx_data), 32'(e));
        end
        check_eq("done_last", 32'(done), 32'(exp_q.size() == 0));
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (done) fin = 1;
      end else begin
        check_eq("done_idle", 32'(done), 0);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      cyc++;
      @(negedge clk);
    end
    send_data = 1'b0;
    in_valid  = 1'b0;
    check_eq("timeout", 32'(fin), 1);
    check_eq("beats", 32'(obs_q.size()), 32'(nbeats));
    #1;
    check_eq("busy_end", 32'(busy), 0);
    check_eq("done_end", 32'(done), 0);
    if (rdy_mode == 0 && vld_mode == 0) begin
      check_eq("contiguous", 32'(last_hs - first_hs + 1), 32'(nbeats));
      if (nbeats < int'(HIST_DEPTH)) begin
        hmask = HIST_DEPTH'((32'd1 << (nbeats + 1)) - 1);
        hexp  = HIST_DEPTH'((32'd1 << nbeats) - 1);
        check_eq("hist", 32'(buff & hmask), 32'(hexp));
      end
    end
  endtask

  task automatic reset_mid_packet();
    int src;
    int cyc;
    bit any_valid;
    bit any_done;
    bit any_busy;
    load_check_string();
    @(negedge clk);
    send_data = 1'b1;
    len_in    = LEN_W'(9);
    tx_ready  = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    send_data = 1'b0;
    src = 0; cyc = 0;
    while (src < 3 && cyc < 50) begin
      in_valid = 1'b1;
      in_data  = pay[src];
      #1;
      if (in_ready) src++;
      cyc++;
      @(negedge clk);
    end
    check_eq("rst_reach", 32'(src), 3);
    in_valid = 1'b0;
    check_eq("rst_pre_valid", 32'(tx_valid), 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_valid", 32'(tx_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_buff", 32'(buff), 0);
    check_eq("rst_data", 32'(tx_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    any_valid = 0; any_done = 0; any_busy = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      any_valid |= tx_valid;
      any_done  |= done;
      any_busy  |= busy;
      @(negedge clk);
    end
    check_eq("rst_no_trailer", 32'(any_valid), 0);
    check_eq("rst_no_done", 32'(any_done), 0);
    check_eq("rst_idle", 32'(any_busy), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    send_data = 1'b0;
    len_in    = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    tx_ready  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_valid", 32'(tx_valid), 0);
    check_eq("reset_data", 32'(tx_data), 0);
    check_eq("reset_busy", 32'(busy), 0);
    check_eq("reset_done", 32'(done), 0);
    check_eq("reset_buff", 32'(buff), 0);
    check_eq("reset_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Check string, full throughput.
    load_check_string();
    run_packet(0, 0, 1'b0);
`ifdef USB_TX_CRC_EN
    if (obs_q.size() == 11) begin
      check_eq("trailer_lo", 32'(obs_q[9]), 32'h0000_00C8);
      check_eq("trailer_hi", 32'(obs_q[10]), 32'h0000_00B4);
    end
`endif

    // Same packet under backpressure.
    load_check_string();
    run_packet(1, 0, 1'b0);

    // Empty packet.
    pay = {};
    run_packet(0, 0, 1'b0);

    // Upstream bubbles with a stray mid-packet start request.
    pay = {8'h01, 8'h02, 8'h03, 8'h04};
    run_packet(0, 1, 1'b1);

    // Two-byte packet and another empty one.
    pay = {8'hA5, 8'h5A};
    run_packet(0, 0, 1'b0);
    pay = {};
    run_packet(2, 0, 1'b0);

    reset_mid_packet();

    for (int p = 0; p < 14; p++) begin
      int plen;
      plen = $urandom_range(0, 20);
      pay  = {};
      for (int i = 0; i < plen; i++) pay.push_back(8'($urandom));
      run_packet($urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
